// File: rtl/fifo_pkg.sv
// Shared defaults and occupancy typedefs for the synchronous FIFO.
package fifo_pkg;
  localparam int DEFAULT_DSIZE = 8;
  localparam int DEFAULT_ASIZE = 4;

  // Pointer/count types at the default geometry (ASIZE+1 bits, wraps modulo 2*DEPTH).
  typedef logic [DEFAULT_ASIZE:0] ptr_t;
  typedef logic [DEFAULT_ASIZE:0] cnt_t;

  function automatic int depth_of(input int asize);
    return 1 << asize;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DSIZE storage: synchronous write port, asynchronous read port.
module fifo_mem #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);
  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with occupancy count, almost flags and overflow/underflow pulses.
// Define FIFO_FWFT_EN for first-word-fall-through read data; default is registered read.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DSIZE    = DEFAULT_DSIZE,
  parameter int ASIZE    = DEFAULT_ASIZE,
  parameter int AF_LEVEL = depth_of(ASIZE) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             wovf,
  output logic             rund
);
  localparam int             DEPTH   = depth_of(ASIZE);
  localparam logic [ASIZE:0] DEPTH_C = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AF_C    = (ASIZE+1)'(AF_LEVEL);
  localparam logic [ASIZE:0] AE_C    = (ASIZE+1)'(AE_LEVEL);

  logic [ASIZE:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic             wovf_q, wovf_d, rund_q, rund_d;
  logic             wr_en, rd_en;
  logic [DSIZE-1:0] mem_rd;

  // Flags derive only from registered pointers, so accepts show up the cycle after the edge.
  assign count         = wptr_q - rptr_q;
  assign wfull         = (count == DEPTH_C);
  assign rempty        = (count == '0);
  assign walmost_full  = (count >= AF_C);
  assign ralmost_empty = (count <= AE_C);

  always_comb begin
    wr_en  = winc && !wfull;
    rd_en  = rinc && !rempty;
    wptr_d = wptr_q + (ASIZE+1)'(wr_en);
    rptr_d = rptr_q + (ASIZE+1)'(rd_en);
    wovf_d = winc && wfull;
    rund_d = rinc && rempty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      wovf_q <= 1'b0;
      rund_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      wovf_q <= wovf_d;
      rund_q <= rund_d;
    end
  end

  assign wovf = wovf_q;
  assign rund = rund_q;

  fifo_mem #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr_q[ASIZE-1:0]),
    .wdata (wdata),
    .raddr (rptr_q[ASIZE-1:0]),
    .rdata (mem_rd)
  );

`ifdef FIFO_FWFT_EN
  // Head word is presented directly; zero while empty keeps the reset value visible.
  assign rdata = rempty ? '0 : mem_rd;
`else
  logic [DSIZE-1:0] rdata_q, rdata_d;

  always_comb rdata_d = rd_en ? mem_rd : rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
`endif
endmodule

// File: tb/tb_param_sync_fifo.sv
// Randomized scoreboard bench for param_sync_fifo; follows FIFO_FWFT_EN when defined.
module tb_param_sync_fifo;
  import fifo_pkg::*;

  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic       clk = 1'b0, rst_n = 1'b0, winc = 1'b0, rinc = 1'b0;
  logic [7:0] wdata = '0;
  logic       wfull, walmost_full, rempty, ralmost_empty, wovf, rund;
  logic [7:0] rdata;
  cnt_t       count;

  int         n_cmp = 0, n_err = 0;
  int         mcnt = 0;
  bit         ewovf = 1'b0, erund = 1'b0, m_wa, m_ra;
  logic [7:0] sb_q[$];
  logic [7:0] exp_rd = '0;

  always #5 clk = ~clk;

  param_sync_fifo #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .wfull(wfull),
    .walmost_full(walmost_full), .rinc(rinc), .rdata(rdata), .rempty(rempty),
    .ralmost_empty(ralmost_empty), .count(count), .wovf(wovf), .rund(rund)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    winc = w; rinc = r; wdata = d;
  endtask

  // Reference model: a FIFO is just a queue plus an occupancy number.
  always @(posedge clk) begin
    if (!rst_n) begin
      mcnt = 0; ewovf = 1'b0; erund = 1'b0; sb_q.delete(); exp_rd = '0;
    end else begin
      m_wa  = winc && (mcnt < DEPTH);
      m_ra  = rinc && (mcnt > 0);
      ewovf = winc && (mcnt == DEPTH);
      erund = rinc && (mcnt == 0);
      if (m_wa) sb_q.push_back(wdata);
      mcnt = mcnt + int'(m_wa) - int'(m_ra);
    end
  end

  always @(negedge rst_n) begin
    mcnt = 0; ewovf = 1'b0; erund = 1'b0; sb_q.delete(); exp_rd = '0;
  end

  // Monitor: consume the expected word whenever the DUT hands one out.
  always @(posedge clk) begin
    if (rst_n && rinc && !rempty) begin
      chk("sb_nonempty", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
`ifdef FIFO_FWFT_EN
        void'(sb_q.pop_front());
`else
        exp_rd = sb_q.pop_front();
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("count", int'(count), mcnt);
      chk("wfull", int'(wfull), int'(mcnt == DEPTH));
      chk("rempty", int'(rempty), int'(mcnt == 0));
      chk("walmost_full", int'(walmost_full), int'(mcnt >= AF));
      chk("ralmost_empty", int'(ralmost_empty), int'(mcnt <= AE));
      chk("wovf", int'(wovf), int'(ewovf));
      chk("rund", int'(rund), int'(erund));
`ifdef FIFO_FWFT_EN
      if (!rempty && sb_q.size() > 0) chk("rdata_fwft", int'(rdata), int'(sb_q[0]));
`else
      chk("rdata", int'(rdata), int'(exp_rd));
`endif
    end
  end

  initial begin
    int pw, pr;
    // Requests held high during reset must be ignored.
    rst_n = 1'b0; winc = 1'b1; rinc = 1'b1; wdata = 8'h77;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_rempty", int'(rempty), 1);
    chk("rst_ralmost_empty", int'(ralmost_empty), 1);
    chk("rst_wfull", int'(wfull), 0);
    chk("rst_walmost_full", int'(walmost_full), 0);
    chk("rst_wovf", int'(wovf), 0);
    chk("rst_rund", int'(rund), 0);
    chk("rst_rdata", int'(rdata), 0);

    // Underflow straight out of reset.
    @(negedge clk);
    rst_n = 1'b1; winc = 1'b0; rinc = 1'b1;
    cyc(0, 0, 0);
    chk("udf_rund", int'(rund), 1);
    chk("udf_rdata", int'(rdata), 0);
    chk("udf_rempty", int'(rempty), 1);
    cyc(0, 0, 0);
    chk("udf_rund_once", int'(rund), 0);

    // Fill, overflow, simultaneous at full.
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 8'(i));
    cyc(0, 0, 0);
    chk("fill_wfull", int'(wfull), 1);
    chk("fill_count", int'(count), 16);
    cyc(1, 0, 8'hAA);
    cyc(0, 0, 0);
    chk("ovf_pulse", int'(wovf), 1);
    chk("ovf_count", int'(count), 16);
    cyc(0, 0, 0);
    chk("ovf_once", int'(wovf), 0);
    cyc(1, 1, 8'hAB);
    cyc(0, 0, 0);
    chk("sim_full_count", int'(count), 15);
    chk("sim_full_wovf", int'(wovf), 1);

    // Drain, then simultaneous at empty.
    repeat (15) cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("drain_rempty", int'(rempty), 1);
    cyc(1, 1, 8'h30);
    cyc(0, 0, 0);
    chk("sim_empty_count", int'(count), 1);
    chk("sim_empty_rund", int'(rund), 1);

    // Hold count at 5 with streaming read+write.
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'(8'h31 + i));
    for (int i = 0; i < 10; i++) cyc(1, 1, 8'(8'h40 + i));
    cyc(0, 0, 0);
    chk("stream_count", int'(count), 5);

    // Randomized traffic across several read/write biases.
    for (int p = 0; p < 6; p++) begin
      pw = 20 + 12 * p;
      pr = 85 - 12 * p;
      for (int i = 0; i < 300; i++)
        cyc(($urandom_range(99) < pw), ($urandom_range(99) < pr), 8'($urandom));
    end

    repeat (DEPTH + 2) cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("rand_drain_rempty", int'(rempty), 1);

    // Single word visibility.
    cyc(1, 0, 8'h5C);
    cyc(0, 0, 0);
    chk("single_rempty", int'(rempty), 0);
`ifdef FIFO_FWFT_EN
    chk("single_fwft_rdata", int'(rdata), 8'h5C);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
`else
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("single_rdata", int'(rdata), 8'h5C);
`endif

    // Asynchronous reset at count 7 discards everything.
    for (int i = 0; i < 7; i++) cyc(1, 0, 8'($urandom));
    cyc(0, 0, 0);
    chk("pre_rst_count", int'(count), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_count", int'(count), 0);
    chk("midrst_rempty", int'(rempty), 1);
    chk("midrst_rdata", int'(rdata), 0);
    chk("midrst_wfull", int'(wfull), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; winc = 1'b1; rinc = 1'b0; wdata = 8'h99;
    cyc(0, 0, 0);
    chk("post_rst_count", int'(count), 1);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("post_rst_rempty", int'(rempty), 1);
    chk("post_rst_rdata", int'(rdata), 8'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
